// File: rtl/dic_load_ctrl_pkg.sv
// Shared types and constants for the digital-clock load controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, ASCII codes for control keys and digit bounds.
package dic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LD_MT = 3'd1,
      LD_MO = 3'd2,
      LD_ST = 3'd3,
      LD_SO = 3'd4
   } dicState_t;

   localparam logic [7:0] ASCII_ESC  = 8'h1B;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_5    = 8'h35;
   localparam logic [7:0] ASCII_9    = 8'h39;
   localparam logic [7:0] ASCII_G_LO = 8'h67;
   localparam logic [7:0] ASCII_G_UP = 8'h47;
   localparam logic [7:0] ASCII_S_LO = 8'h73;
   localparam logic [7:0] ASCII_S_UP = 8'h53;
   localparam logic [7:0] ASCII_N_LO = 8'h6E;
   localparam logic [7:0] ASCII_N_UP = 8'h4E;
   localparam logic [7:0] ASCII_L_LO = 8'h6C;
   localparam logic [7:0] ASCII_L_UP = 8'h4C;

endpackage

// File: rtl/dic_load_ctrl_if.sv
// Key-stream input and clock-datapath command bundle for dic_load_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; the receiver strobes characters and the controller always accepts.
// Ports: i_rx_data/i_rx_valid/i_oneSecStrb toward the controller; o_* commands from it.
interface dic_load_ctrl_if;

   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       i_oneSecStrb;
   logic       o_ldMtens;
   logic       o_ldMones;
   logic       o_ldStens;
   logic       o_ldSones;
   logic [3:0] o_ld_num;
   logic       o_dicRun;
   logic       o_dicSelectLEDdisp;
   logic       o_loading;
   logic       o_err;

   // Key source / clock datapath side.
   modport master (
      output i_rx_data, i_rx_valid, i_oneSecStrb,
      input  o_ldMtens, o_ldMones, o_ldStens, o_ldSones, o_ld_num,
      input  o_dicRun, o_dicSelectLEDdisp, o_loading, o_err
   );

   // Controller side.
   modport slave (
      input  i_rx_data, i_rx_valid, i_oneSecStrb,
      output o_ldMtens, o_ldMones, o_ldStens, o_ldSones, o_ld_num,
      output o_dicRun, o_dicSelectLEDdisp, o_loading, o_err
   );

endinterface

// File: rtl/dic_load_ctrl_timeout_cnt.sv
// 4-bit saturating inactivity counter; expired while count equals TIMEOUT_SEC.
// Latency: count updates one cycle after clr/inc; expired follows the registered count.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), clr (wins over inc), inc, expired.
module dic_timeout_cnt #(
   parameter int unsigned TIMEOUT_SEC = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [3:0] LIMIT = 4'(TIMEOUT_SEC);

   logic [3:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && count != 4'hF) begin
         count <= count + 4'd1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/dic_load_ctrl.sv
// Turns a received ASCII key stream into MM:SS digit-load strobes, run/freeze and LED-select pulses.
// Latency: every output is registered, responding one cycle after the i_rx_valid cycle.
// Backpressure: none; a character is processed on every cycle i_rx_valid is high.
// Ports: clk, rst (sync, active-high), bus (dic_load_ctrl_if.slave).
module dic_load_ctrl
   import dic_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = 10
) (
   input  logic             clk,
   input  logic             rst,
   dic_load_ctrl_if.slave   bus
);

   dicState_t  state;
   logic       savedRun;
   logic       ldMtens, ldMones, ldStens, ldSones;
   logic [3:0] ldNum;
   logic       dicRun, selLed, loading, err;
   logic       expired;
   logic       isDigit05, isDigit09, digitOk;

   // Any key while loading restarts the inactivity window; in IDLE the
   // counter is held clear so that entering LD_MT starts from zero.
   dic_timeout_cnt #(.TIMEOUT_SEC(TIMEOUT_SEC)) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.i_rx_valid || state == IDLE),
      .inc     (bus.i_oneSecStrb && state != IDLE),
      .expired (expired)
   );

   // Tens positions accept 0..5, ones positions 0..9.
   assign isDigit09 = (bus.i_rx_data >= ASCII_0) && (bus.i_rx_data <= ASCII_9);
   assign isDigit05 = (bus.i_rx_data >= ASCII_0) && (bus.i_rx_data <= ASCII_5);
   assign digitOk   = (state == LD_MT || state == LD_ST) ? isDigit05 : isDigit09;

   always_ff @(posedge clk) begin
      // Pulse outputs default low every cycle.
      ldMtens <= 1'b0;
      ldMones <= 1'b0;
      ldStens <= 1'b0;
      ldSones <= 1'b0;
      ldNum   <= 4'd0;
      selLed  <= 1'b0;
      err     <= 1'b0;
      if (rst) begin
         state    <= IDLE;
         savedRun <= 1'b0;
         dicRun   <= 1'b0;
         loading  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_rx_valid) begin
                  if (bus.i_rx_data == ASCII_G_LO || bus.i_rx_data == ASCII_G_UP) begin
                     dicRun <= 1'b1;
                  end else if (bus.i_rx_data == ASCII_S_LO || bus.i_rx_data == ASCII_S_UP) begin
                     dicRun <= 1'b0;
                  end else if (bus.i_rx_data == ASCII_N_LO || bus.i_rx_data == ASCII_N_UP) begin
                     selLed <= 1'b1;
                  end else if (bus.i_rx_data == ASCII_L_LO || bus.i_rx_data == ASCII_L_UP) begin
                     savedRun <= dicRun;
                     dicRun   <= 1'b0;
                     loading  <= 1'b1;
                     state    <= LD_MT;
                  end
               end
            end
            LD_MT, LD_MO, LD_ST, LD_SO: begin
               // A key in the same cycle as expiry wins over the timeout.
               if (bus.i_rx_valid) begin
                  if (bus.i_rx_data == ASCII_ESC) begin
                     dicRun  <= savedRun;
                     loading <= 1'b0;
                     state   <= IDLE;
                  end else if (digitOk) begin
                     ldNum <= 4'(bus.i_rx_data - ASCII_0);
                     case (state)
                        LD_MT: begin ldMtens <= 1'b1; state <= LD_MO; end
                        LD_MO: begin ldMones <= 1'b1; state <= LD_ST; end
                        LD_ST: begin ldStens <= 1'b1; state <= LD_SO; end
                        default: begin
                           ldSones <= 1'b1;
                           dicRun  <= 1'b1;
                           loading <= 1'b0;
                           state   <= IDLE;
                        end
                     endcase
                  end else begin
                     err <= 1'b1;
                  end
               end else if (expired) begin
                  dicRun  <= savedRun;
                  loading <= 1'b0;
                  err     <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               dicRun  <= 1'b0;
               loading <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ldMtens          = ldMtens;
   assign bus.o_ldMones          = ldMones;
   assign bus.o_ldStens          = ldStens;
   assign bus.o_ldSones          = ldSones;
   assign bus.o_ld_num           = ldNum;
   assign bus.o_dicRun           = dicRun;
   assign bus.o_dicSelectLEDdisp = selLed;
   assign bus.o_loading          = loading;
   assign bus.o_err              = err;

endmodule

// File: tb/tb_dic_load_ctrl.sv
// Scoreboard bench for dic_load_ctrl: a key-level reference model predicts the output
// vector for each driven cycle; a monitor on the opposite clock edge pops and compares.
// Stimulus: directed scenarios followed by randomized key/strobe/reset traffic.
module tb_dic_load_ctrl;

   localparam int TIMEOUT = 10;

   typedef struct packed {
      logic       ldMt;
      logic       ldMo;
      logic       ldSt;
      logic       ldSo;
      logic [3:0] num;
      logic       run;
      logic       sel;
      logic       loading;
      logic       err;
   } outs_t;

   logic clk;
   logic rst;
   dic_load_ctrl_if bus();

   dic_load_ctrl #(.TIMEOUT_SEC(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   outs_t sbq[$];
   int    errors = 0;
   int    checks = 0;
   int    cycle  = 0;

   // Reference model: position -1 means not loading, 0..3 is the next digit to enter.
   int mPos   = -1;
   bit mRun   = 0;
   bit mSaved = 0;
   int mSecs  = 0;

   task automatic modelStep(input bit r, input bit v, input logic [7:0] d, input bit s,
                            output outs_t o);
      logic [7:0] lc;
      int maxDigit;
      o = '0;
      lc = d | 8'h20;
      if (r) begin
         mPos = -1; mRun = 0; mSaved = 0; mSecs = 0;
         return;
      end
      if (mPos < 0) begin
         mSecs = 0;
         if (v) begin
            if (lc == "g" && (d == "g" || d == "G")) mRun = 1;
            else if (d == "s" || d == "S") mRun = 0;
            else if (d == "n" || d == "N") o.sel = 1;
            else if (d == "l" || d == "L") begin
               mSaved = mRun; mRun = 0; mPos = 0;
            end
         end
      end else begin
         if (v) begin
            mSecs = 0;
            maxDigit = (mPos % 2 == 0) ? 5 : 9;
            if (d == 8'h1B) begin
               mPos = -1; mRun = mSaved;
            end else if (d >= "0" && d <= "9" && int'(d) - 48 <= maxDigit) begin
               o.num = 4'(int'(d) - 48);
               case (mPos)
                  0: o.ldMt = 1;
                  1: o.ldMo = 1;
                  2: o.ldSt = 1;
                  default: o.ldSo = 1;
               endcase
               mPos++;
               if (mPos == 4) begin
                  mPos = -1; mRun = 1;
               end
            end else begin
               o.err = 1;
            end
         end else if (mSecs >= TIMEOUT) begin
            mPos = -1; mRun = mSaved; o.err = 1;
         end else if (s) begin
            mSecs = (mSecs < 15) ? mSecs + 1 : 15;
         end
      end
      o.run     = mRun;
      o.loading = (mPos >= 0);
   endtask

   // Drive one cycle of inputs (1 time unit after the falling edge) and queue the prediction.
   task automatic step(input bit v, input logic [7:0] d, input bit s, input bit r);
      outs_t e;
      @(negedge clk);
      #1;
      rst              = r;
      bus.i_rx_valid   = v;
      bus.i_rx_data    = d;
      bus.i_oneSecStrb = s;
      modelStep(r, v, d, s, e);
      sbq.push_back(e);
   endtask

   task automatic key(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic secs(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
   endtask

   // Monitor: compares the DUT outputs registered at the previous rising edge.
   initial begin
      outs_t act, exp;
      forever begin
         @(negedge clk);
         cycle++;
         if (sbq.size() > 0) begin
            exp = sbq.pop_front();
            act.ldMt    = bus.o_ldMtens;
            act.ldMo    = bus.o_ldMones;
            act.ldSt    = bus.o_ldStens;
            act.ldSo    = bus.o_ldSones;
            act.num     = bus.o_ld_num;
            act.run     = bus.o_dicRun;
            act.sel     = bus.o_dicSelectLEDdisp;
            act.loading = bus.o_loading;
            act.err     = bus.o_err;
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL outputs cycle=%0d actual{mt,mo,st,so,num,run,sel,ld,err}=%b_%b_%b_%b_%h_%b_%b_%b_%b required=%b_%b_%b_%b_%h_%b_%b_%b_%b",
                        cycle, act.ldMt, act.ldMo, act.ldSt, act.ldSo, act.num, act.run, act.sel,
                        act.loading, act.err, exp.ldMt, exp.ldMo, exp.ldSt, exp.ldSo, exp.num,
                        exp.run, exp.sel, exp.loading, exp.err);
            end
         end
      end
   end

   initial begin
      logic [7:0] keys [16];
      bit phaseQuiet;
      rst = 1'b1;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_oneSecStrb = 1'b0;
      keys = '{"0", "1", "5", "6", "9", "3", "g", "G", "s", "S", "n", "N", "l", "L", 8'h1B, "x"};

      // Reset state.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      idle(2);

      // Run / stop.
      key("g"); idle(1); key("s"); idle(1);

      // Full load, latency-1 strobes, end running.
      key("l"); key("1"); key("2"); key("3"); key("4"); idle(2);

      // Out-of-range tens digit rejected, then accepted; 'n' rejected while loading.
      key("l"); key("7"); key("5"); key("n"); key("9"); key(8'h1B); idle(1);

      // ESC restores run=1 after one strobe.
      key("G"); key("L"); key("0"); key(8'h1B); idle(2);

      // Timeout abort with saved run restored.
      key("l"); secs(TIMEOUT); idle(3);

      // Key coincides with the 10th strobe: no timeout, window restarts.
      key("s"); key("l"); secs(TIMEOUT - 1);
      step(1'b1, "2", 1'b1, 1'b0);
      secs(TIMEOUT - 1); idle(2); key(8'h1B); idle(1);

      // Reset mid-load in LD_ST, then '1' ignored and 'n' selects.
      key("g"); key("l"); key("1"); key("2");
      step(1'b0, 8'h00, 1'b0, 1'b1);
      key("1"); key("n"); idle(1);

      // Randomized traffic, alternating busy and quiet phases to reach timeouts.
      phaseQuiet = 0;
      for (int i = 0; i < 4000; i++) begin
         bit v, s, r;
         if (i % 200 == 0) phaseQuiet = ~phaseQuiet;
         r = ($urandom_range(0, 599) == 0);
         v = phaseQuiet ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 45);
         s = phaseQuiet ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10);
         step(v, keys[$urandom_range(0, 15)], s, r);
      end
      idle(2);

      @(negedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
